spike_count_classifier: RTL and testbench
=========================================

SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

Interface
REQ-001 SHALL have parameter NUM_OUTPUTS, default 10, number of output neurons / spike lanes from the IF network.
REQ-002 SHALL have parameter WINDOW, default 100, classification window length in timesteps (clock cycles); legal range 1..65535.
REQ-003 SHALL have parameter COUNT_WIDTH, default 8, width of each per-lane spike counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to begin one classification window.
REQ-007 SHALL have port spike_in  input  NUM_OUTPUTS  spike vector from the IF network output layer, one bit per neuron per timestep.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port label_valid  output  1  one-cycle pulse marking a new result.
REQ-010 SHALL have port label  output  clog2(NUM_OUTPUTS) (min 1)  index of the winning lane.
REQ-011 SHALL have port max_count  output  COUNT_WIDTH  spike count of the winning lane.
REQ-012 SHALL have port no_spike  output  1  high with the result when every lane counted zero.

Function
REQ-013 SHALL implement FSM states IDLE, COUNT, ARGMAX, DONE.
REQ-014 IDLE: start=1 at edge k -> all lane counters and the window counter cleared, next state COUNT; start=0 -> remain IDLE.
REQ-015 COUNT: spike_in sampled at edges k+1..k+WINDOW inclusive (exactly WINDOW samples); each set bit increments its lane counter by 1.
REQ-016 Lane counters SHALL saturate at 2^COUNT_WIDTH-1 and never wrap.
REQ-017 After the WINDOW-th sample: state ARGMAX; spike_in ignored outside COUNT.
REQ-018 ARGMAX: sequential scan, one lane per cycle, index 0..NUM_OUTPUTS-1, NUM_OUTPUTS cycles total; candidate replaced only on strictly greater count -> ties resolve to lowest index.
REQ-019 DONE: one cycle; label_valid=1; label, max_count, no_spike update together with that pulse; next state IDLE.
REQ-020 Latency: label_valid high in the cycle after edge k+WINDOW+NUM_OUTPUTS+1; start ignored while busy=1 (no queueing).
REQ-021 label, max_count, no_spike SHALL hold their values until the next label_valid pulse.
REQ-022 start=1 in the DONE cycle is ignored; start=1 in the IDLE cycle immediately after DONE is accepted (back-to-back windows).
REQ-023 no_spike=1 iff max_count=0; in that case label=0.

Reset
REQ-024 rst=1 at any edge, any state (including mid-COUNT or mid-ARGMAX) -> state IDLE, counters cleared, busy=0, label_valid=0, label=0, max_count=0, no_spike=0; any in-progress window discarded with no result.
REQ-025 rst has priority over start at the same edge.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding and a clog2-based width helper for label and window counter.
REQ-027 One sub-module sat_counter (parameter WIDTH; clear, inc, count) SHALL be instantiated NUM_OUTPUTS times via generate.
REQ-028 Window counter width SHALL be clog2(WINDOW+1); no multi-cycle or combinational NUM_OUTPUTS-wide comparator tree.

Verification (NUM_OUTPUTS=4, WINDOW=8, COUNT_WIDTH=4 unless stated)
REQ-029 start pulse, spike_in=4'b0100 every cycle -> label_valid exactly 13 edges after start acceptance, label=2, max_count=8, no_spike=0.
REQ-030 spike_in=4'b1010 constant for the window -> tie, label=1, max_count=8.
REQ-031 spike_in=0 for whole window -> label=0, max_count=0, no_spike=1.
REQ-032 COUNT_WIDTH=2, lane 3 spiking all 8 cycles, lane 0 spiking 2 cycles -> max_count=3 (saturated), label=3.
REQ-033 rst asserted at 5th COUNT cycle -> no label_valid, outputs zero, busy=0; new start then yields correct result; start pulses during busy produce no extra label_valid.
REQ-034 start held high continuously -> back-to-back results, label_valid every 14 cycles.

Source files
------------

// File: rtl/spike_count_classifier_pkg.sv
// Shared types and width helpers for the spike count classifier.
// Holds the FSM encoding and the clog2-based width function.
package spike_count_classifier_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;

  // clog2 with a floor of one bit
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spike_count_classifier_sat.sv
// Per-lane saturating spike counter.
// Synchronous clear wins over increment; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/spike_count_classifier.sv
// Counts output-layer spikes over a fixed window, then picks the
// busiest lane with a one-lane-per-cycle sequential argmax.
module spike_count_classifier
  import spike_count_classifier_pkg::*;
#(
  parameter int NUM_OUTPUTS = 10,
  parameter int WINDOW      = 100,
  parameter int COUNT_WIDTH = 8,
  localparam int LW         = width_of(NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_OUTPUTS-1:0] spike_in,
  output logic                   busy,
  output logic                   label_valid,
  output logic [LW-1:0]          label,
  output logic [COUNT_WIDTH-1:0] max_count,
  output logic                   no_spike
);

  localparam int WW = width_of(WINDOW + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(NUM_OUTPUTS - 1);

  state_t                 state;
  logic [WW-1:0]          win_cnt;
  logic [LW-1:0]          scan_idx;
  logic [LW-1:0]          best_idx;
  logic [COUNT_WIDTH-1:0] best_cnt;
  logic [COUNT_WIDTH-1:0] sel_cnt;
  logic                   lane_clear;
  logic [COUNT_WIDTH-1:0] lane_cnt [NUM_OUTPUTS];

  assign lane_clear = rst || ((state == IDLE) && start);

  genvar g;
  generate
    for (g = 0; g < NUM_OUTPUTS; g++) begin : g_lane
      sat_counter #(
        .WIDTH (COUNT_WIDTH)
      ) u_cnt (
        .clk   (clk),
        .clear (lane_clear),
        .inc   ((state == COUNT) && spike_in[g]),
        .count (lane_cnt[g])
      );
    end
  endgenerate

  // single comparator walks the lanes; no parallel max tree
  assign sel_cnt = lane_cnt[scan_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      win_cnt     <= '0;
      scan_idx    <= '0;
      best_idx    <= '0;
      best_cnt    <= '0;
      busy        <= 1'b0;
      label_valid <= 1'b0;
      label       <= '0;
      max_count   <= '0;
      no_spike    <= 1'b0;
    end else begin
      label_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= COUNT;
            win_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        COUNT: begin
          win_cnt <= win_cnt + WW'(1);
          if (win_cnt == WIN_LAST) begin
            state    <= ARGMAX;
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
          end
        end
        ARGMAX: begin
          if (sel_cnt > best_cnt) begin
            best_cnt <= sel_cnt;
            best_idx <= scan_idx;
          end
          scan_idx <= scan_idx + LW'(1);
          if (scan_idx == LANE_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          label_valid <= 1'b1;
          label       <= best_idx;
          max_count   <= best_cnt;
          no_spike    <= (best_cnt == '0);
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Scoreboard bench: two classifiers (4-bit and 2-bit counters)
// share stimulus; a monitor checks every label_valid pulse.
module tb_spike_count_classifier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] spike = 4'd0;

  logic       busy1, lv1, ns1;
  logic [1:0] lab1;
  logic [3:0] mx1;
  logic       busy2, lv2, ns2;
  logic [1:0] lab2;
  logic [1:0] mx2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int lbl;
    int mx;
    int ns;
    int due;
  } exp_t;

  exp_t q1 [$];
  exp_t q2 [$];

  spike_count_classifier #(
    .NUM_OUTPUTS (4),
    .WINDOW      (8),
    .COUNT_WIDTH (4)
  ) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .spike_in    (spike),
    .busy        (busy1),
    .label_valid (lv1),
    .label       (lab1),
    .max_count   (mx1),
    .no_spike    (ns1)
  );

  spike_count_classifier #(
    .NUM_OUTPUTS (4),
    .WINDOW      (8),
    .COUNT_WIDTH (2)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .spike_in    (spike),
    .busy        (busy2),
    .label_valid (lv2),
    .label       (lab2),
    .max_count   (mx2),
    .no_spike    (ns2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (lv1) begin
      if (q1.size() == 0) begin
        check("dut4_unexpected_valid", 1, 0);
      end else begin
        e = q1.pop_front();
        check("dut4_label", int'(lab1), e.lbl);
        check("dut4_max", int'(mx1), e.mx);
        check("dut4_no_spike", int'(ns1), e.ns);
        check("dut4_latency", cyc, e.due);
      end
    end
    if (lv2) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_valid", 1, 0);
      end else begin
        e = q2.pop_front();
        check("dut2_label", int'(lab2), e.lbl);
        check("dut2_max", int'(mx2), e.mx);
        check("dut2_no_spike", int'(ns2), e.ns);
        check("dut2_latency", cyc, e.due);
      end
    end
  end

  task automatic expect_both(input int l4, input int m4,
                             input int l2, input int m2,
                             input int due);
    q1.push_back('{lbl: l4, mx: m4, ns: (m4 == 0), due: due});
    q2.push_back('{lbl: l2, mx: m2, ns: (m2 == 0), due: due});
  endtask

  // seq[4*i +: 4] is the spike vector for sample i
  task automatic run_win(input logic [31:0] seq,
                         input int l4, input int m4,
                         input int l2, input int m2,
                         input bit poke);
    int c;
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    expect_both(l4, m4, l2, m2, c + 14);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy1), 1);
    spike = seq[3:0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      spike = seq[4*i +: 4];
      start = poke;
    end
    @(negedge clk);
    spike = 4'hf;
    repeat (4) begin
      @(negedge clk);
      start = poke;
    end
    @(negedge clk);
    start = 1'b0;
    spike = 4'd0;
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(busy1), 0);
    check("rst_valid", int'(lv1), 0);
    check("rst_label", int'(lab1), 0);
    check("rst_max", int'(mx1), 0);
    check("rst_no_spike", int'(ns1), 0);

    run_win({8{4'b0100}}, 2, 8, 2, 3, 1'b0);
    run_win({8{4'b1010}}, 1, 8, 1, 3, 1'b0);
    run_win(32'd0, 0, 0, 0, 0, 1'b0);
    run_win({{6{4'b1000}}, 4'b1001, 4'b1001}, 3, 8, 3, 3, 1'b0);
    run_win({4'b0000, 4'b0010, 4'b0010, {5{4'b0011}}}, 1, 7, 0, 3, 1'b0);

    // abort mid-window: reset lands on the 5th counting edge
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    spike = 4'b0100;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy4", int'(busy1), 0);
    check("abort_busy2", int'(busy2), 0);
    check("abort_label", int'(lab1), 0);
    check("abort_max", int'(mx1), 0);
    check("abort_no_spike", int'(ns1), 0);
    check("abort_valid", int'(lv1), 0);
    repeat (15) @(negedge clk);
    check("abort_idle_cycles", cyc - c, 21);

    run_win({4'b0000, 4'b1000, 4'b1100, 4'b1110,
             4'b1111, 4'b0111, 4'b0011, 4'b0001}, 0, 4, 0, 3, 1'b0);
    run_win({{5{4'b0100}}, {3{4'b1000}}}, 2, 5, 2, 3, 1'b1);

    // start held high: results every 14 cycles
    @(negedge clk);
    c = cyc;
    start = 1'b1;
    spike = 4'b0100;
    expect_both(2, 8, 2, 3, c + 14);
    expect_both(2, 8, 2, 3, c + 28);
    expect_both(2, 8, 2, 3, c + 42);
    repeat (42) @(negedge clk);
    start = 1'b0;
    spike = 4'd0;

    for (int i = 0; i < 40 && (q1.size() + q2.size()) != 0; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", q1.size() + q2.size(), 0);
    check("final_busy", int'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
